// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the shift sequencer: FSM state encoding,
// datapath sizing, and the per-cycle step clamp.
package shift_seq_pkg;

  localparam int unsigned WIDTH_DEF    = 8;
  localparam int unsigned SHW_DEF      = 3;
  localparam int unsigned STEP_MAX_DEF = 3;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} seq_state_t;

  function automatic int unsigned min_step(input int unsigned rem, input int unsigned step_max);
    return (rem < step_max) ? rem : step_max;
  endfunction

endpackage

// File: rtl/step_right_shift.sv
// Combinational logical right shift by a small amount (zero fill).
module step_right_shift #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input  logic [SHW-1:0]   amt,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb dout = din >> amt;

endmodule

// File: rtl/shift_sequencer.sv
// Round-robin shared right shifter: one request at a time, executed as a
// sequence of steps of at most STEP_MAX bits each.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned SHW      = SHW_DEF,
  parameter int unsigned STEP_MAX = STEP_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] data0,
  input  logic [SHW-1:0]   shift0,
  input  logic [WIDTH-1:0] data1,
  input  logic [SHW-1:0]   shift1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] shout,
  output logic             rsp_id
);

  seq_state_t       state, state_nxt;
  logic             prio;
  logic             id;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   rem;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic [SHW-1:0]   sel_shift;
  logic [SHW-1:0]   step;
  logic [WIDTH-1:0] shifted;

  assign grant     = req_valid[prio] ? prio : ~prio;
  assign sel_data  = grant ? data1 : data0;
  assign sel_shift = grant ? shift1 : shift0;
  assign step      = SHW'(min_step(32'(rem), STEP_MAX));

  step_right_shift #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_step (
    .amt (step),
    .din (acc),
    .dout(shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // rst_n gates req_ready so no grant is advertised while reset is asserted.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (req_valid != 2'b00)) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_nxt        = (sel_shift == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (rem == step) state_nxt = DONE;
      end
      DONE: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      rem  <= '0;
      id   <= 1'b0;
      prio <= 1'b0;
    end else if (accept) begin
      acc  <= sel_data;
      rem  <= sel_shift;
      id   <= grant;
      prio <= ~grant;
    end else if (state == SHIFT) begin
      acc <= shifted;
      rem <= rem - step;
    end
  end

  assign rsp_valid = (state == DONE);
  assign shout     = rsp_valid ? acc : '0;
  assign rsp_id    = rsp_valid & id;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: arbitration order, step latency,
// result hold under backpressure and mid-transaction reset.
module tb_shift_sequencer;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] data0, data1;
  logic [2:0] shift0, shift1;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] shout;
  logic       rsp_id;

  int tests;
  int fails;

  shift_sequencer #(
    .WIDTH   (8),
    .SHW     (3),
    .STEP_MAX(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .data0    (data0),
    .shift0   (shift0),
    .data1    (data1),
    .shift1   (shift1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .shout    (shout),
    .rsp_id   (rsp_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request, measures cycles to rsp_valid, checks the result,
  // optionally holds it with rsp_ready low for 5 cycles, then completes it.
  task automatic run_job(input string tag, input int who, input logic [1:0] vmask,
                         input logic [7:0] d, input logic [2:0] s,
                         input logic [7:0] exp_out, input int exp_lat, input bit hold);
    int n;
    logic [7:0] held;
    if (who == 0) begin data0 = d; shift0 = s; end
    else          begin data1 = d; shift1 = s; end
    rsp_ready = !hold;
    req_valid = vmask;
    #1;
    check({tag, ".grant"}, 32'(req_ready), (who == 0) ? 32'h1 : 32'h2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    n = 1;
    while (!rsp_valid && n < 20) begin
      check({tag, ".busy_ready"}, 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(exp_lat));
    check({tag, ".shout"}, 32'(shout), 32'(exp_out));
    check({tag, ".rsp_id"}, 32'(rsp_id), 32'(who));
    if (hold) begin
      held = shout;
      req_valid = 2'b11;
      repeat (5) begin
        @(posedge clk); #1;
        check({tag, ".hold_valid"}, 32'(rsp_valid), 32'h1);
        check({tag, ".hold_shout"}, 32'(shout), 32'(held));
        check({tag, ".hold_id"}, 32'(rsp_id), 32'(who));
        check({tag, ".hold_ready"}, 32'(req_ready), 32'h0);
      end
      req_valid = 2'b00;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, ".after_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, ".after_shout"}, 32'(shout), 32'h0);
    check({tag, ".after_id"}, 32'(rsp_id), 32'h0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset.req_ready", 32'(req_ready), 32'h0);
    check("reset.rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset.shout", 32'(shout), 32'h0);
    check("reset.rsp_id", 32'(rsp_id), 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    data0 = '0; data1 = '0;
    shift0 = '0; shift1 = '0;
    @(posedge clk); #1;
    do_reset();

    // Basic jobs: 3-bit shift, full 7-bit shift, zero shift.
    run_job("t1", 0, 2'b01, 8'hB4, 3'd3, 8'h16, 2, 1'b0);
    run_job("t2", 1, 2'b10, 8'hFF, 3'd7, 8'h01, 4, 1'b0);
    data0 = 8'h00; shift0 = 3'd5;
    #2;
    run_job("t3", 0, 2'b01, 8'h5A, 3'd0, 8'h5A, 1, 1'b0);

    // Round-robin with both requesters active from a fresh reset.
    do_reset();
    run_job("t4a", 0, 2'b11, 8'h80, 3'd1, 8'h40, 2, 1'b0);
    run_job("t4b", 1, 2'b11, 8'hF0, 3'd4, 8'h0F, 3, 1'b0);
    run_job("t4c", 0, 2'b11, 8'h81, 3'd6, 8'h02, 3, 1'b0);

    // Lone requester 0 while prio points at 1, result held under backpressure.
    run_job("t5", 0, 2'b01, 8'hC3, 3'd2, 8'h30, 2, 1'b1);

    // Reset in cycle 2 of a shift=7 job.
    data0 = 8'hFF; shift0 = 3'd7;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6.abort_valid", 32'(rsp_valid), 32'h0);
    check("t6.abort_shout", 32'(shout), 32'h0);
    check("t6.abort_ready", 32'(req_ready), 32'h0);
    check("t6.abort_id", 32'(rsp_id), 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      check("t6.held_valid", 32'(rsp_valid), 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6.idle_valid", 32'(rsp_valid), 32'h0);
    run_job("t6post", 0, 2'b01, 8'hB4, 3'd3, 8'h16, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
